// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side drain.
package fifo_pkg;

    localparam int DRAIN_BUF_DEPTH = 32'sd2;

    typedef logic [1:0] occ_t;

    // Counter width for n states; a single-state counter still needs one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 32'sd1) begin
            cnt_width = 32'sd1;
        end else begin
            cnt_width = w;
        end
    endfunction

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_drain.
interface fifo_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_val;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_val,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_val,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer: head/tail pointers over two registers, push and pop
// may occur in the same cycle even when full.
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  occ,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] entry0_r;
    logic [DATA_WIDTH-1:0] entry1_r;
    logic                  head_r;
    logic                  tail_r;
    occ_t                  occ_r;
    occ_t                  occ_nxt_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Qualify push/pop and compute next occupancy.
    always_comb begin
        pop_ok_s  = pop & (occ_r != 2'd0);
        push_ok_s = push & ((occ_r != 2'(DRAIN_BUF_DEPTH)) | pop_ok_s);
        occ_nxt_s = occ_r;
        if (push_ok_s && !pop_ok_s) begin
            occ_nxt_s = occ_r + 2'd1;
        end else if (!push_ok_s && pop_ok_s) begin
            occ_nxt_s = occ_r - 2'd1;
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Storage, pointers and occupancy; when full, a simultaneous push reuses the slot the head vacates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry0_r <= {DATA_WIDTH{1'b0}};
            entry1_r <= {DATA_WIDTH{1'b0}};
            head_r   <= 1'b0;
            tail_r   <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                if (tail_r) begin
                    entry1_r <= push_data;
                end else begin
                    entry0_r <= push_data;
                end
                tail_r <= ~tail_r;
            end
            if (pop_ok_s) begin
                head_r <= ~head_r;
            end
            occ_r <= occ_nxt_s;
        end
    end

    assign head_data = head_r ? entry1_r : entry0_r;
    assign occ       = occ_r;
    assign full      = (occ_r == 2'(DRAIN_BUF_DEPTH));

endmodule

// File: rtl/fifo_drain.sv
// Read-side FIFO consumer: issues pulls, buffers the one-cycle-late responses
// in a skid buffer and presents them as a packet-framed valid/ready stream.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    fifo_drain_if.master     bus,
    output logic             idle,
    output logic             ovf_err
);

    localparam int               BEAT_W    = cnt_width(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    occ_t                  occ_s;
    logic                  full_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  capture_s;
    logic                  rd_en_s;
    logic [2:0]            need_s;
    logic                  pend_r;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic                  ovf_err_r;

    // Pull decision: only pull if the word can land without exceeding two entries.
    always_comb begin
        valid_s   = (occ_s != 2'd0);
        pop_s     = valid_s & bus.out_ready;
        need_s    = {1'b0, occ_s} + {2'b00, pend_r} - {2'b00, pop_s};
        rd_en_s   = reset & enable & (need_s <= 3'd1);
        capture_s = pend_r & bus.fifo_rd_val;
    end

    fifo_drain_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (capture_s),
        .push_data (bus.fifo_rd_data),
        .pop       (pop_s),
        .head_data (head_data_s),
        .occ       (occ_s),
        .full      (full_s)
    );

    // In-flight pull marker, packet beat counter and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r     <= 1'b0;
            beat_cnt_r <= {BEAT_W{1'b0}};
            ovf_err_r  <= 1'b0;
        end else begin
            pend_r <= rd_en_s;
            if (pop_s) begin
                if (beat_cnt_r == LAST_BEAT) begin
                    beat_cnt_r <= {BEAT_W{1'b0}};
                end else begin
                    beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                end
            end
            if (capture_s && full_s && !pop_s) begin
                ovf_err_r <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.out_valid  = valid_s;
    assign bus.out_data   = head_data_s;
    assign bus.out_last   = valid_s & (beat_cnt_r == LAST_BEAT);
    // Reset counts as "not enabled" so the block reports idle while held in reset.
    assign idle           = ~(reset & enable) & ~valid_s & ~pend_r;
    assign ovf_err        = ovf_err_r;

endmodule

// File: tb/tb_fifo_drain.sv
// Directed table-driven bench for fifo_drain with a small FIFO response model.
module tb_fifo_drain;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       exp_rd_en;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic       exp_idle;
    } vec_t;

    logic clk;
    logic reset;
    logic enable;
    logic idle;
    logic ovf_err;

    fifo_drain_if #(.DATA_WIDTH(8)) bus ();

    fifo_drain #(
        .DATA_WIDTH (8),
        .PKT_LEN    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bus     (bus),
        .idle    (idle),
        .ovf_err (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t       vecs[$];
    logic [7:0] model_mem[0:15];
    int         model_rd;
    int         model_fill;
    int         model_starve;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic rdy, input logic rd,
                                input logic val, input logic [7:0] d,
                                input logic last, input logic idl);
        vec_t v;
        v.en = en; v.rdy = rdy; v.exp_rd_en = rd; v.exp_valid = val;
        v.exp_data = d; v.exp_last = last; v.exp_idle = idl;
        vecs.push_back(v);
    endfunction

    task automatic load_model(input logic [7:0] base, input int n, input int starve);
        for (int i = 0; i < n; i++) model_mem[i] = base + 8'(i);
        model_fill   = n;
        model_rd     = 0;
        model_starve = starve;
    endtask

    // One cycle: entered at posedge+1; outputs sampled at the negedge; FIFO model answers after the edge.
    task automatic do_cycle(input vec_t v, input string tag, input int idx);
        logic rd;
        enable        = v.en;
        bus.out_ready = v.rdy;
        #4;
        chk($sformatf("%s[%0d] rd_en", tag, idx), {7'd0, bus.fifo_rd_en}, {7'd0, v.exp_rd_en});
        chk($sformatf("%s[%0d] valid", tag, idx), {7'd0, bus.out_valid}, {7'd0, v.exp_valid});
        chk($sformatf("%s[%0d] last", tag, idx), {7'd0, bus.out_last}, {7'd0, v.exp_last});
        chk($sformatf("%s[%0d] idle", tag, idx), {7'd0, idle}, {7'd0, v.exp_idle});
        chk($sformatf("%s[%0d] ovf", tag, idx), {7'd0, ovf_err}, 8'd0);
        if (v.exp_valid) begin
            chk($sformatf("%s[%0d] data", tag, idx), bus.out_data, v.exp_data);
        end
        rd = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        bus.fifo_rd_val = 1'b0;
        if (rd) begin
            if (model_starve > 0) begin
                model_starve--;
            end else if (model_rd < model_fill) begin
                bus.fifo_rd_val  = 1'b1;
                bus.fifo_rd_data = model_mem[model_rd];
                model_rd++;
            end
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) do_cycle(vecs[i], tag, i);
        vecs.delete();
    endtask

    // Apply reset with enable/out_ready high, check reset values, release at posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset            = 1'b0;
        enable           = 1'b1;
        bus.out_ready    = 1'b1;
        bus.fifo_rd_val  = 1'b0;
        bus.fifo_rd_data = 8'h00;
        @(posedge clk);
        #2;
        chk("rst rd_en", {7'd0, bus.fifo_rd_en}, 8'd0);
        chk("rst valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst last", {7'd0, bus.out_last}, 8'd0);
        chk("rst data", bus.out_data, 8'h00);
        chk("rst idle", {7'd0, idle}, 8'd1);
        chk("rst ovf", {7'd0, ovf_err}, 8'd0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Streaming at full rate
        do_reset();
        load_model(8'h11, 8, 0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add(1'b1, 1'b1, 1'b1, 1'b1, 8'h11 + 8'(i), (i == 3) || (i == 7), 1'b0);
        end
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        run_table("stream");

        // Back-pressure: out_ready low for cycles 3-7
        do_reset();
        load_model(8'h11, 8, 0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            add(1'b1, 1'b1, 1'b1, 1'b1, 8'h13 + 8'(i), (i == 1) || (i == 5), 1'b0);
        end
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_table("bp");

        // Empty FIFO for four responses, then data; beat counter must not move
        do_reset();
        load_model(8'hA5, 4, 4);
        for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5 + 8'(i), i == 3, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_table("empty");

        // Enable drop after two beats, then re-enable mid-packet
        do_reset();
        load_model(8'h21, 8, 0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h21, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            add(1'b1, 1'b1, 1'b1, 1'b1, 8'h24 + 8'(i), (i == 0) || (i == 4), 1'b0);
        end
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        run_table("endrop");

        // Asynchronous reset with two words buffered
        do_reset();
        load_model(8'h31, 8, 0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
        run_table("arst_pre");
        #2;
        chk("arst full valid", {7'd0, bus.out_valid}, 8'd1);
        chk("arst full data", bus.out_data, 8'h31);
        chk("arst full rd_en", {7'd0, bus.fifo_rd_en}, 8'd0);
        reset = 1'b0;
        #1;
        chk("arst valid", {7'd0, bus.out_valid}, 8'd0);
        chk("arst last", {7'd0, bus.out_last}, 8'd0);
        chk("arst rd_en", {7'd0, bus.fifo_rd_en}, 8'd0);
        chk("arst idle", {7'd0, idle}, 8'd1);
        enable           = 1'b0;
        bus.fifo_rd_val  = 1'b1;
        bus.fifo_rd_data = 8'hEE;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        load_model(8'h41, 8, 0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            add(1'b1, 1'b1, 1'b1, 1'b1, 8'h41 + 8'(i), i == 3, 1'b0);
        end
        run_table("arst_post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
